// File: rtl/stage5_writeback.sv
// Writeback stage: commits ALU results directly and load results after the
// data-memory response, aligning/extending the loaded byte/half/word.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   mem_*_i / mem_ready_o         retiring instruction from MEM (valid/ready)
//   dmem_rvalid_i, dmem_rdata_i   data-memory read response
//   dec_r1_addr_i, dec_r2_addr_i  decode-stage source indices
//   wb_data_o, rd_addr_o          register file write data / index
//   rf_rw_en_o                    register file write enable
//   fwd_a_o, fwd_b_o              forward selects towards decode
//   load_stall_o, load_err_o      load pending / committed load error
//   retire_o, retired_cnt_o       commit pulse / committed count
module stage5_writeback #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            mem_valid_i,
   output logic            mem_ready_o,
   input  logic [4:0]      mem_rd_addr_i,
   input  logic            mem_rd_en_i,
   input  logic            mem_is_load_i,
   input  logic [2:0]      mem_funct3_i,
   input  logic [1:0]      mem_addr_lsb_i,
   input  logic [XLEN-1:0] mem_alu_res_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   input  logic [4:0]      dec_r1_addr_i,
   input  logic [4:0]      dec_r2_addr_i,
   output logic [XLEN-1:0] wb_data_o,
   output logic [4:0]      rd_addr_o,
   output logic            rf_rw_en_o,
   output logic            fwd_a_o,
   output logic            fwd_b_o,
   output logic            load_stall_o,
   output logic            load_err_o,
   output logic            retire_o,
   output logic [63:0]     retired_cnt_o
);

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } state_e;

   state_e          state_q;
   logic [4:0]      ld_rd_q;
   logic            ld_rd_en_q;
   logic [2:0]      ld_f3_q;
   logic [1:0]      ld_off_q;
   logic [XLEN-1:0] wb_data_q;
   logic [4:0]      rd_addr_q;
   logic            rf_en_q;
   logic            err_q;
   logic            retire_q;
   logic [63:0]     cnt_q;

   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] ld_data;
   logic            ld_err;

   // Alignment works on the latched size/offset and the live response word.
   always_comb begin
      ld_err   = 1'b0;
      ld_data  = '0;
      byte_sel = dmem_rdata_i[{ld_off_q, 3'b000} +: 8];
      half_sel = dmem_rdata_i[{ld_off_q[1], 4'b0000} +: 16];
      case (ld_f3_q)
         3'b000: ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b100: ld_data = {{(XLEN-8){1'b0}}, byte_sel};
         3'b001: begin
            if (ld_off_q[0]) ld_err = 1'b1;
            else ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         end
         3'b101: begin
            if (ld_off_q[0]) ld_err = 1'b1;
            else ld_data = {{(XLEN-16){1'b0}}, half_sel};
         end
         3'b010: begin
            if (ld_off_q != 2'b00) ld_err = 1'b1;
            else ld_data = dmem_rdata_i;
         end
         default: ld_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ld_rd_q    <= '0;
         ld_rd_en_q <= 1'b0;
         ld_f3_q    <= '0;
         ld_off_q   <= '0;
         wb_data_q  <= '0;
         rd_addr_q  <= '0;
         rf_en_q    <= 1'b0;
         err_q      <= 1'b0;
         retire_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         retire_q <= 1'b0;
         rf_en_q  <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               // A response seen here is stale and deliberately dropped.
               if (mem_valid_i) begin
                  if (mem_is_load_i) begin
                     state_q    <= WAIT_LOAD;
                     ld_rd_q    <= mem_rd_addr_i;
                     ld_rd_en_q <= mem_rd_en_i;
                     ld_f3_q    <= mem_funct3_i;
                     ld_off_q   <= mem_addr_lsb_i;
                  end else begin
                     retire_q  <= 1'b1;
                     wb_data_q <= mem_alu_res_i;
                     rd_addr_q <= mem_rd_addr_i;
                     rf_en_q   <= mem_rd_en_i &&
                                  (mem_rd_addr_i != 5'd0);
                     cnt_q     <= cnt_q + 64'd1;
                  end
               end
            end
            WAIT_LOAD: begin
               if (dmem_rvalid_i) begin
                  state_q   <= IDLE;
                  retire_q  <= 1'b1;
                  wb_data_q <= ld_data;
                  rd_addr_q <= ld_rd_q;
                  err_q     <= ld_err;
                  rf_en_q   <= ld_rd_en_q && (ld_rd_q != 5'd0) &&
                               !ld_err;
                  cnt_q     <= cnt_q + 64'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_ready_o   = (state_q == IDLE);
   assign load_stall_o  = (state_q == WAIT_LOAD);
   assign wb_data_o     = wb_data_q;
   assign rd_addr_o     = rd_addr_q;
   assign rf_rw_en_o    = rf_en_q;
   assign load_err_o    = err_q;
   assign retire_o      = retire_q;
   assign retired_cnt_o = cnt_q;
   assign fwd_a_o       = rf_en_q && (rd_addr_q == dec_r1_addr_i);
   assign fwd_b_o       = rf_en_q && (rd_addr_q == dec_r2_addr_i);

endmodule

// File: tb/tb_stage5_writeback.sv
// Self-checking bench for stage5_writeback: directed scenarios followed by
// randomized ALU/load traffic checked against a behavioural load model.
module tb_stage5_writeback;

   logic        clk;
   logic        rst_n;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd_addr;
   logic        mem_rd_en;
   logic        mem_is_load;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_addr_lsb;
   logic [31:0] mem_alu_res;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic [4:0]  dec_r1;
   logic [4:0]  dec_r2;
   logic [31:0] wb_data;
   logic [4:0]  rd_addr;
   logic        rf_rw_en;
   logic        fwd_a;
   logic        fwd_b;
   logic        load_stall;
   logic        load_err;
   logic        retire;
   logic [63:0] cnt;

   int          total;
   int          bad;
   logic [63:0] cnt_exp;

   stage5_writeback #(.XLEN(32)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .mem_valid_i   (mem_valid),
      .mem_ready_o   (mem_ready),
      .mem_rd_addr_i (mem_rd_addr),
      .mem_rd_en_i   (mem_rd_en),
      .mem_is_load_i (mem_is_load),
      .mem_funct3_i  (mem_funct3),
      .mem_addr_lsb_i(mem_addr_lsb),
      .mem_alu_res_i (mem_alu_res),
      .dmem_rvalid_i (dmem_rvalid),
      .dmem_rdata_i  (dmem_rdata),
      .dec_r1_addr_i (dec_r1),
      .dec_r2_addr_i (dec_r2),
      .wb_data_o     (wb_data),
      .rd_addr_o     (rd_addr),
      .rf_rw_en_o    (rf_rw_en),
      .fwd_a_o       (fwd_a),
      .fwd_b_o       (fwd_b),
      .load_stall_o  (load_stall),
      .load_err_o    (load_err),
      .retire_o      (retire),
      .retired_cnt_o (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      mem_valid   = 1'b0;
      mem_is_load = 1'b0;
      dmem_rvalid = 1'b0;
   endtask

   // Reference load behaviour from the size/sign rules, in plain arithmetic.
   task automatic ref_load(input logic [2:0] f3, input int off,
                           input logic [31:0] rdata,
                           output logic [31:0] val, output logic err);
      longint unsigned w;
      longint unsigned v;
      w   = longint'(rdata);
      v   = 0;
      err = 1'b0;
      case (f3)
         3'd0, 3'd4: begin
            v = (w / (256 ** off)) % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            if (off % 2 != 0) err = 1'b1;
            v = (w / (65536 ** (off / 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
         end
         3'd2: begin
            if (off != 0) err = 1'b1;
            v = w;
         end
         default: err = 1'b1;
      endcase
      if (err) v = 0;
      val = v[31:0];
   endtask

   task automatic check_commit(input logic [4:0] rd,
                               input logic [31:0] data,
                               input logic en, input logic err);
      logic rfen;
      rfen    = en && (rd != 5'd0) && !err;
      cnt_exp = cnt_exp + 64'd1;
      chk("retire", 64'(retire), 64'd1);
      chk("rd_addr", 64'(rd_addr), 64'(rd));
      chk("wb_data", 64'(wb_data), 64'(data));
      chk("rf_rw_en", 64'(rf_rw_en), 64'(rfen));
      chk("load_err", 64'(load_err), 64'(err));
      chk("retired_cnt", cnt, cnt_exp);
      chk("ready_commit", 64'(mem_ready), 64'd1);
      chk("stall_commit", 64'(load_stall), 64'd0);
      chk("fwd_a", 64'(fwd_a), 64'(rfen && rd == dec_r1));
      chk("fwd_b", 64'(fwd_b), 64'(rfen && rd == dec_r2));
   endtask

   task automatic do_alu(input logic [4:0] rd, input logic en,
                         input logic [31:0] res);
      mem_valid    = 1'b1;
      mem_is_load  = 1'b0;
      mem_rd_addr  = rd;
      mem_rd_en    = en;
      mem_alu_res  = res;
      mem_funct3   = 3'($urandom_range(7, 0));
      mem_addr_lsb = 2'($urandom_range(3, 0));
      tick();
      set_idle();
      check_commit(rd, res, en, 1'b0);
   endtask

   task automatic do_load(input logic [4:0] rd, input logic en,
                          input logic [2:0] f3, input logic [1:0] off,
                          input logic [31:0] rdata, input int lat,
                          input logic early_rv);
      logic [31:0] v;
      logic        e;
      mem_valid    = 1'b1;
      mem_is_load  = 1'b1;
      mem_rd_addr  = rd;
      mem_rd_en    = en;
      mem_funct3   = f3;
      mem_addr_lsb = off;
      mem_alu_res  = $urandom;
      dmem_rvalid  = early_rv;
      dmem_rdata   = ~rdata;
      tick();
      set_idle();
      for (int i = 0; i < lat; i++) begin
         chk("ready_wait", 64'(mem_ready), 64'd0);
         chk("stall_wait", 64'(load_stall), 64'd1);
         chk("retire_wait", 64'(retire), 64'd0);
         if (i == lat - 1) begin
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
         end
         tick();
      end
      dmem_rvalid = 1'b0;
      ref_load(f3, int'(off), rdata, v, e);
      check_commit(rd, v, en, e);
   endtask

   task automatic do_idle(input logic rv);
      set_idle();
      dmem_rvalid = rv;
      dmem_rdata  = $urandom;
      tick();
      dmem_rvalid = 1'b0;
      chk("retire_idle", 64'(retire), 64'd0);
      chk("rfen_idle", 64'(rf_rw_en), 64'd0);
      chk("err_idle", 64'(load_err), 64'd0);
      chk("cnt_idle", cnt, cnt_exp);
      chk("ready_idle", 64'(mem_ready), 64'd1);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      cnt_exp      = '0;
      rst_n        = 1'b0;
      mem_rd_addr  = '0;
      mem_rd_en    = 1'b0;
      mem_funct3   = '0;
      mem_addr_lsb = '0;
      mem_alu_res  = '0;
      dmem_rdata   = '0;
      dec_r1       = '0;
      dec_r2       = '0;
      set_idle();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb", 64'(wb_data), 64'd0);
      chk("rst_rd", 64'(rd_addr), 64'd0);
      chk("rst_rfen", 64'(rf_rw_en), 64'd0);
      chk("rst_retire", 64'(retire), 64'd0);
      chk("rst_err", 64'(load_err), 64'd0);
      chk("rst_cnt", cnt, 64'd0);
      chk("rst_fwd", 64'({fwd_a, fwd_b}), 64'd0);
      chk("rst_ready", 64'(mem_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // back-to-back ALU commits
      dec_r1 = 5'd9;
      dec_r2 = 5'd9;
      do_alu(5'd5, 1'b1, 32'h0000_1234);
      do_alu(5'd6, 1'b1, 32'hCAFE_0006);
      do_idle(1'b0);

      // sized loads, 3-cycle latency
      do_load(5'd10, 1'b1, 3'b000, 2'd3, 32'h80FF_FF7F, 3, 1'b0);
      chk("lb_value", 64'(wb_data), 64'hFFFF_FF80);
      do_load(5'd11, 1'b1, 3'b101, 2'd2, 32'h80FF_FF7F, 3, 1'b0);
      chk("lhu_value", 64'(wb_data), 64'h0000_80FF);

      // misaligned word, then response racing acceptance
      do_load(5'd12, 1'b1, 3'b010, 2'd1, 32'h1234_5678, 2, 1'b0);
      do_load(5'd13, 1'b1, 3'b010, 2'd0, 32'hA5A5_0F0F, 2, 1'b1);
      do_idle(1'b1);

      // x0 write and forward selects
      dec_r1 = 5'd0;
      dec_r2 = 5'd3;
      do_alu(5'd0, 1'b1, 32'hDEAD_BEEF);
      dec_r1 = 5'd1;
      dec_r2 = 5'd7;
      do_alu(5'd7, 1'b1, 32'h0000_0077);
      do_idle(1'b0);
      chk("fwd_b_drop", 64'(fwd_b), 64'd0);

      // reset during a pending load discards it
      mem_valid    = 1'b1;
      mem_is_load  = 1'b1;
      mem_rd_addr  = 5'd14;
      mem_rd_en    = 1'b1;
      mem_funct3   = 3'b010;
      mem_addr_lsb = 2'd0;
      tick();
      set_idle();
      chk("pre_rst_stall", 64'(load_stall), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      cnt_exp = '0;
      chk("mid_rst_ready", 64'(mem_ready), 64'd1);
      chk("mid_rst_out", 64'({wb_data, rd_addr, rf_rw_en,
                               retire, load_err}), 64'd0);
      chk("mid_rst_cnt", cnt, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_idle(1'b1);
      chk("post_rst_wb", 64'(wb_data), 64'd0);

      // counter wrap
      force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.cnt_q;
      #1;
      cnt_exp = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("cnt_forced", cnt, cnt_exp);
      do_alu(5'd4, 1'b1, 32'h0000_0044);
      chk("cnt_wrap", cnt, 64'd0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         logic [4:0] rd;
         int         kind;
         rd     = 5'($urandom_range(31, 0));
         kind   = int'($urandom_range(9, 0));
         dec_r1 = ($urandom_range(1, 0) == 1) ? rd :
                  5'($urandom_range(31, 0));
         dec_r2 = ($urandom_range(1, 0) == 1) ? rd :
                  5'($urandom_range(31, 0));
         if (kind < 4)
            do_alu(rd, 1'($urandom_range(1, 0)), $urandom);
         else if (kind < 9)
            do_load(rd, 1'($urandom_range(1, 0)),
                    3'($urandom_range(7, 0)),
                    2'($urandom_range(3, 0)), $urandom,
                    int'($urandom_range(4, 1)),
                    1'($urandom_range(1, 0)));
         else
            do_idle(1'($urandom_range(1, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stage5_writeback.md
STAGE5_WRITEBACK -- requirements
Module: stage5_writeback

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 mem_valid_i  input  1  MEM stage presents a retiring instruction.
REQ-005 mem_ready_o  output  1  block accepts the instruction this cycle.
REQ-006 mem_rd_addr_i  input  5  destination register index.
REQ-007 mem_rd_en_i  input  1  instruction writes rd.
REQ-008 mem_is_load_i  input  1  instruction is a load.
REQ-009 mem_funct3_i  input  3  load size/sign encoding.
REQ-010 mem_addr_lsb_i  input  2  load byte offset.
REQ-011 mem_alu_res_i  input  XLEN  result for non-load instructions.
REQ-012 dmem_rvalid_i  input  1  data memory read response valid.
REQ-013 dmem_rdata_i  input  XLEN  data memory read word.
REQ-014 dec_r1_addr_i, dec_r2_addr_i  input  5 each  decode-stage source indices.
REQ-015 wb_data_o  output  XLEN  register file write data.
REQ-016 rd_addr_o  output  5  register file write index.
REQ-017 rf_rw_en_o  output  1  register file write enable.
REQ-018 fwd_a_o, fwd_b_o  output  1 each  decode-stage forward selects.
REQ-019 load_stall_o  output  1  a load response is pending.
REQ-020 load_err_o  output  1  committed load was misaligned or had an illegal funct3.
REQ-021 retire_o  output  1  one-cycle commit pulse.
REQ-022 retired_cnt_o  output  64  count of committed instructions.

Function
REQ-023 The FSM SHALL have two states: IDLE (mem_ready_o=1) and WAIT_LOAD (mem_ready_o=0, load_stall_o=1).
REQ-024 In IDLE, mem_valid_i=1 accepts the instruction. A non-load stays in IDLE. A load moves to WAIT_LOAD and latches rd, rd_en, funct3 and the byte offset.
REQ-025 For an accepted non-load, in the next cycle retire_o SHALL be 1, wb_data_o SHALL equal mem_alu_res_i, and rd_addr_o SHALL equal mem_rd_addr_i; back-to-back acceptance SHALL sustain one commit per cycle.
REQ-026 In WAIT_LOAD, dmem_rvalid_i=1 SHALL return the FSM to IDLE and commit the aligned load in the next cycle. mem_ready_o is 1 in that commit cycle.
REQ-027 dmem_rvalid_i SHALL be ignored in IDLE, including a response arriving in the same cycle a load is accepted.
REQ-028 Load alignment: LB(000)/LBU(100) select byte [8*off+7:8*off]; LH(001)/LHU(101) select halfword [16*off[1]+15:16*off[1]]; LW(010) selects the full word. LB/LH sign-extend, LBU/LHU zero-extend.
REQ-029 LH/LHU with off[0]=1, LW with off≠0, and funct3 in {011,110,111} SHALL raise load_err_o for the commit cycle and suppress rf_rw_en_o; wb_data_o SHALL be 0.
REQ-030 rf_rw_en_o = retire_o AND rd_en AND rd≠0 AND no error; it is never 1 for x0.
REQ-031 fwd_a_o = rf_rw_en_o AND (rd_addr_o == dec_r1_addr_i); fwd_b_o is the same against dec_r2_addr_i. Both are combinational from registered outputs.
REQ-032 retired_cnt_o SHALL increment by 1 on every retire_o cycle, including x0, no-write and errored commits. It wraps from 2^64-1 to 0.
REQ-033 retire_o, rf_rw_en_o and load_err_o SHALL be single-cycle pulses per committed instruction.

Reset
REQ-034 While rst_ni=0: state=IDLE; wb_data_o, rd_addr_o, rf_rw_en_o, retire_o, load_err_o and retired_cnt_o = 0; fwd_a_o=fwd_b_o=0; mem_ready_o=1.
REQ-035 Reset asserted in WAIT_LOAD SHALL discard the pending load; a response arriving after reset release in IDLE is ignored per REQ-027.

Verification
REQ-036 ALU op rd=5, res=0x1234 accepted, then rd=6 next cycle -> commits on consecutive cycles; rf_rw_en_o=1 both; retired_cnt_o 0->1->2.
REQ-037 LB off=3, rdata=0x80FF_FF7F -> wb_data_o=0xFFFF_FF80. LHU off=2 on the same rdata -> 0x0000_80FF. Each load has 3 cycles of rvalid latency; mem_ready_o=0 and load_stall_o=1 throughout the wait.
REQ-038 LW off=1 -> load_err_o=1, rf_rw_en_o=0, retire_o=1, counter increments.
REQ-039 Commit rd=0 with rd_en=1 and dec_r1_addr_i=0 -> rf_rw_en_o=0, fwd_a_o=0. Commit rd=7 with dec_r2_addr_i=7 -> fwd_b_o=1 for exactly that cycle.
REQ-040 rst_ni pulsed low during WAIT_LOAD, then rvalid arrives -> no commit, all outputs 0, mem_ready_o=1.
REQ-041 Counter forced to 0xFFFF_FFFF_FFFF_FFFF, then one commit -> retired_cnt_o=0.
